sys_bus_initiator: RTL

Bus master for the Red Pitaya system bus: the initiator counterpart of the memory-mapped user register blocks. It accepts single read/write commands on a valid/ready port and issues one-cycle sys_wen/sys_ren strobes. It waits for sys_ack with a bounded timeout and returns read data or status on a valid/ready response port. It lets on-chip sequencers (test engines, script players) drive any responder on the system bus without the PS.

---
 rtl/sys_bus_pkg.sv | 6 +
 rtl/sys_bus_initiator.sv | 84 ++++++++
 2 files changed

// File: rtl/sys_bus_pkg.sv
// sys_bus_pkg: shared system-bus widths and initiator FSM state encoding
package sys_bus_pkg;
  localparam int BUS_AW = 32;
  localparam int BUS_DW = 32;
  typedef enum logic [1:0] {IDLE, STROBE, WAIT, RESP} bus_state_t;
endpackage

// File: rtl/sys_bus_initiator.sv
// sys_bus_initiator: single-outstanding system-bus master with ack timeout
module sys_bus_initiator
  import sys_bus_pkg::*;
#(
  parameter int TMO_CYCLES = 255,
  parameter int TMO_W      = 16
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_we_i,
  input  logic [BUS_AW-1:0] cmd_addr_i,
  input  logic [BUS_DW-1:0] cmd_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [BUS_DW-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              rsp_tmo_o,
  output logic [BUS_AW-1:0] sys_addr_o,
  output logic [BUS_DW-1:0] sys_wdata_o,
  output logic              sys_wen_o,
  output logic              sys_ren_o,
  input  logic [BUS_DW-1:0] sys_rdata_i,
  input  logic              sys_err_i,
  input  logic              sys_ack_i,
  output logic              busy_o,
  output logic [TMO_W-1:0]  tmo_cnt_o
);
  bus_state_t       state;
  logic             we;
  logic [TMO_W-1:0] cnt;
  assign cmd_ready_o = state == IDLE;
  assign busy_o      = state != IDLE;
  assign rsp_valid_o = state == RESP;
  // Acks outside WAIT are ignored, so late acks after a timeout cannot retrigger a response
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state       <= IDLE;
      we          <= 1'b0;
      cnt         <= '0;
      sys_addr_o  <= '0;
      sys_wdata_o <= '0;
      sys_wen_o   <= 1'b0;
      sys_ren_o   <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
      rsp_tmo_o   <= 1'b0;
      tmo_cnt_o   <= '0;
    end else begin
      sys_wen_o <= 1'b0;
      sys_ren_o <= 1'b0;
      case (state)
        IDLE: if (cmd_valid_i) begin
          sys_addr_o  <= cmd_addr_i;
          sys_wdata_o <= cmd_wdata_i;
          we          <= cmd_we_i;
          sys_wen_o   <= cmd_we_i;
          sys_ren_o   <= !cmd_we_i;
          state       <= STROBE;
        end
        STROBE: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: if (sys_ack_i) begin
          rsp_rdata_o <= (!we && !sys_err_i) ? sys_rdata_i : '0;
          rsp_err_o   <= sys_err_i;
          rsp_tmo_o   <= 1'b0;
          state       <= RESP;
        end else if (cnt == TMO_W'(TMO_CYCLES - 1)) begin
          rsp_rdata_o <= '0;
          rsp_err_o   <= 1'b1;
          rsp_tmo_o   <= 1'b1;
          tmo_cnt_o   <= (&tmo_cnt_o) ? tmo_cnt_o : tmo_cnt_o + TMO_W'(1);
          state       <= RESP;
        end else begin
          cnt <= cnt + TMO_W'(1);
        end
        RESP: if (rsp_ready_i) state <= IDLE;
      endcase
    end
  end
endmodule
